// File: rtl/shift_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : shift_result_buffer
// Description : Registered FIFO stage behind the SLL shifter. Tags each result
//               with an illegal-operation flag and hands it to writeback over a
//               valid/ready handshake. Optional macro SHIFT_BUF_ZERO_FLAG_EN
//               adds a per-entry out_zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_result_buffer #(
    parameter int         DEPTH    = 4,
    parameter int         PTR_W    = 2,
    parameter logic [5:0] SLL_CODE = 6'b000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [5:0]       in_signal,
    input  logic [26:0]      in_shamt_hi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [5:0]       out_signal,
    output logic             out_err,
`ifdef SHIFT_BUF_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic [PTR_W:0]   count,
    output logic             overflow_sticky
);

    localparam logic [PTR_W:0] c_FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_dataMem [DEPTH];
    logic [5:0]       r_signalMem [DEPTH];
    logic             r_errMem [DEPTH];
    logic [PTR_W-1:0] r_rdPtr;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W:0]   r_count;
    logic             r_overflow;

    logic w_push;
    logic w_pop;
    logic w_notEmpty;
    logic w_inErr;

    assign w_notEmpty = (r_count != '0);
    assign in_ready   = (r_count != c_FULL_COUNT) | out_ready;
    assign out_valid  = w_notEmpty;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = w_notEmpty & out_ready;
    assign w_inErr    = (in_signal != SLL_CODE) | (in_shamt_hi != '0);

    // Head is read straight from storage; gating with occupancy gives zeroed
    // outputs out of reset without clearing the storage array.
    assign out_data   = w_notEmpty ? r_dataMem[r_rdPtr]   : '0;
    assign out_signal = w_notEmpty ? r_signalMem[r_rdPtr] : '0;
    assign out_err    = w_notEmpty ? r_errMem[r_rdPtr]    : 1'b0;

    assign count           = r_count;
    assign overflow_sticky = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_dataMem[r_wrPtr]   <= in_data;
            r_signalMem[r_wrPtr] <= in_signal;
            r_errMem[r_wrPtr]    <= w_inErr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef SHIFT_BUF_ZERO_FLAG_EN
    logic r_zeroMem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_zeroMem[r_wrPtr] <= (in_data == '0);
        end
    end

    assign out_zero = w_notEmpty ? r_zeroMem[r_rdPtr] : 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_result_buffer
// Description : Self-checking bench for shift_result_buffer against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_result_buffer;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  sig;
        logic        err;
        logic        zero;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [5:0]  in_signal;
    logic [26:0] in_shamt_hi;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [5:0]  out_signal;
    logic        out_err;
`ifdef SHIFT_BUF_ZERO_FLAG_EN
    logic        out_zero;
`endif
    logic [PTR_W:0] count;
    logic        overflow_sticky;

    int     checks = 0;
    int     errors = 0;
    entry_t q[$];
    bit     expOvf = 0;

    shift_result_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W), .SLL_CODE(6'b000000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_signal       (in_signal),
        .in_shamt_hi     (in_shamt_hi),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_signal      (out_signal),
        .out_err         (out_err),
`ifdef SHIFT_BUF_ZERO_FLAG_EN
        .out_zero        (out_zero),
`endif
        .count           (count),
        .overflow_sticky (overflow_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        check("count", 64'(count), 64'(q.size()));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("overflow_sticky", 64'(overflow_sticky), 64'(expOvf));
        if (q.size() != 0) begin
            check("out_data", 64'(out_data), 64'(q[0].data));
            check("out_signal", 64'(out_signal), 64'(q[0].sig));
            check("out_err", 64'(out_err), 64'(q[0].err));
`ifdef SHIFT_BUF_ZERO_FLAG_EN
            check("out_zero", 64'(out_zero), 64'(q[0].zero));
`endif
        end else begin
            check("out_data_empty", 64'(out_data), 64'd0);
            check("out_signal_empty", 64'(out_signal), 64'd0);
            check("out_err_empty", 64'(out_err), 64'd0);
`ifdef SHIFT_BUF_ZERO_FLAG_EN
            check("out_zero_empty", 64'(out_zero), 64'd0);
`endif
        end
    endtask

    // One clock of stimulus: drive, check in_ready, advance the model, check.
    task automatic cycle(input bit v, input bit rdy, input logic [31:0] d,
                         input logic [5:0] s, input logic [26:0] h);
        bit     expReady;
        bit     doPush;
        bit     doPop;
        entry_t e;
        in_valid    = v;
        out_ready   = rdy;
        in_data     = d;
        in_signal   = s;
        in_shamt_hi = h;
        #1;
        expReady = (q.size() != DEPTH) || rdy;
        check("in_ready", 64'(in_ready), 64'(expReady));
        doPush = v && expReady;
        doPop  = rdy && (q.size() != 0);
        if (v && !expReady) expOvf = 1'b1;
        e.data = d;
        e.sig  = s;
        e.err  = (s != 6'd0) || (h != 27'd0);
        e.zero = (d == 32'd0);
        @(posedge clk);
        if (doPop) void'(q.pop_front());
        if (doPush) q.push_back(e);
        #1;
        checkOutputs();
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_data     = '0;
        in_signal   = '0;
        in_shamt_hi = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutputs();
        rst_n = 1'b1;

        // Single entry then pop
        cycle(1, 0, 32'h0000_00F0, 6'd0, 27'd0);
        cycle(0, 1, 32'h0, 6'd0, 27'd0);

        // Fill, attempt overflow, then stream while full, then drain
        for (int i = 1; i <= 4; i++) cycle(1, 0, 32'(i), 6'd0, 27'd0);
        cycle(1, 0, 32'd99, 6'd0, 27'd0);
        for (int i = 5; i <= 10; i++) cycle(1, 1, 32'(i), 6'd0, 27'd0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h0, 6'd0, 27'd0);

        // Error tagging and zero flag
        cycle(1, 0, 32'h1234_5678, 6'b000010, 27'd0);
        cycle(1, 0, 32'h0, 6'd0, 27'h1);
        cycle(1, 0, 32'h0000_0010, 6'd0, 27'd0);
        cycle(1, 0, 32'h8000_0000, 6'd0, 27'd0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 32'h0, 6'd0, 27'd0);

        // Back-pressure hold with two entries
        cycle(1, 0, 32'hCAFE_0001, 6'd5, 27'd0);
        cycle(1, 0, 32'hCAFE_0002, 6'd0, 27'd0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 32'hDEAD_BEEF, 6'd7, 27'd3);

        // Asynchronous reset in the middle of a cycle
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        q.delete();
        expOvf = 1'b0;
        #1;
        checkOutputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            logic [5:0]  s;
            logic [26:0] h;
            d = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            h = ($urandom_range(0, 5) == 0) ? 27'($urandom_range(1, 1000)) : 27'd0;
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), d, s, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_result_buffer.md
Name: shift_result_buffer

Overview:
- Registered output stage directly downstream of the combinational SLL shifter.
- Captures each shifter result together with its 6-bit function code and an out-of-range flag, then queues it in a small FIFO.
- Presents the head entry to the writeback/result-select logic using a valid/ready handshake.
- Decouples the combinational shift path from writeback stalls, and flags shift amounts that the shifter forces to zero.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- PTR_W, 2, pointer width; must equal log2(DEPTH).
- SLL_CODE, 6'b000000, function code that identifies a legal shift-left-logical.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents a result this cycle
- in_ready  output  1  buffer can accept an entry this cycle
- in_data  input  32  shifter dataOut
- in_signal  input  6  function code that accompanied the shift
- in_shamt_hi  input  27  upper shift-amount bits, dataB[31:5]
- out_valid  output  1  head entry is available
- out_ready  input  1  downstream accepts the head entry
- out_data  output  32  head result
- out_signal  output  6  head function code
- out_err  output  1  head entry was illegal (bad code or shift amount >= 32)
- count  output  PTR_W+1  current occupancy, 0..DEPTH
- overflow_sticky  output  1  set when a push is attempted while the buffer is full

Behaviour:
- Reset, asynchronous on rst_n low:
  - read pointer = 0, write pointer = 0, count = 0.
  - out_valid = 0, overflow_sticky = 0.
  - out_data, out_signal and out_err = 0.
  - Entry storage is not cleared.
  - An asserted reset mid-operation discards all queued entries immediately.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (count != DEPTH) | out_ready. A full buffer accepts a push in the same cycle it pops.
  - out_valid = (count != 0). The head is combinational from storage at the read pointer; there is no extra output register.
- Latency:
  - An entry pushed at clock edge N is visible on out_* after edge N.
  - Minimum one-cycle latency; there is no bypass.
- Error tag, computed at push:
  - err = (in_signal != SLL_CODE) | (in_shamt_hi != 0).
  - in_data is stored unchanged; the shifter has already zeroed it.
- Pointers:
  - Both pointers wrap modulo DEPTH.
  - count is explicit: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Empty:
  - out_valid = 0, and out_ready is ignored.
  - A simultaneous push while empty has no pop; the entry appears on the next cycle.
- Full:
  - Without out_ready: in_ready = 0, and the entry is not written.
  - With out_ready: push and pop both occur, and count stays at DEPTH.
- overflow_sticky:
  - Sets on the cycle in_valid = 1 and in_ready = 0.
  - Clears only on reset.
- While out_valid = 1 and out_ready = 0, out_* must hold stable.

Optional Feature:
- Macro: SHIFT_BUF_ZERO_FLAG_EN.
- Defined:
  - Adds output out_zero (1 bit), equal to (head out_data == 0).
  - out_zero is stored per entry at push time.
  - It resets to 0 and follows the same stability rule as out_*.
- Undefined:
  - The port is absent and there is no storage for it.
  - All other behaviour is identical.

Test Plan:
- Reset, single entry:
  - rst_n low then high; push in_data = 32'h0000_00F0, in_signal = 0, in_shamt_hi = 0.
  - Next cycle: out_valid = 1, out_data = 32'h0000_00F0, out_err = 0, count = 1.
  - Pop: count = 0, out_valid = 0.
- Fill to full, DEPTH = 4:
  - Push 1, 2, 3, 4 with out_ready = 0.
  - Result: count = 4, in_ready = 0.
  - Attempt a fifth push: overflow_sticky = 1, and the stored data is unchanged.
  - Drain: outputs come out in order 1, 2, 3, 4.
- Simultaneous push and pop when full:
  - count = 4, in_valid = 1 and out_ready = 1 for 6 cycles with data 5..10.
  - count stays 4; the output sequence continues 1, 2, 3, 4, 5, 6; pointers wrap correctly.
- Error tagging:
  - Push in_signal = 6'b000010 → out_err = 1.
  - Push in_signal = 0, in_shamt_hi = 27'h1 → out_err = 1.
  - Push in_signal = 0, in_shamt_hi = 0 → out_err = 0.
- Back-pressure stability and mid-operation reset:
  - Hold out_ready = 0 for 5 cycles with count = 2; out_data and out_signal must be unchanged on every cycle.
  - Pulse rst_n low mid-cycle: count = 0, out_valid = 0, overflow_sticky = 0 immediately, before the next clock edge.
- Zero flag, with SHIFT_BUF_ZERO_FLAG_EN defined:
  - Push 32'h0 → out_zero = 1.
  - Push 32'h8000_0000 → out_zero = 0.
